// File: rtl/capture_ctrl.sv
// Capture/readout sequencer for the sample BRAM: arm -> trigger -> DEPTH writes -> FULL -> ready-gated readout.
// Optional macro CAPTURE_DECIM_EN adds DECIM and i_decim_bypass to write only every DECIM-th valid sample.
module capture_ctrl #(
    parameter int NB_ADDR      = 11,
    parameter int DEPTH        = 2048,
    parameter int READ_LATENCY = 1
`ifdef CAPTURE_DECIM_EN
    ,
    parameter int DECIM        = 4
`endif
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_arm,
    input  logic               i_trigger,
    input  logic               i_sample_valid,
    input  logic               i_readout_req,
    input  logic               i_rd_ready,
`ifdef CAPTURE_DECIM_EN
    input  logic               i_decim_bypass,
`endif
    output logic               o_write_enable,
    output logic [NB_ADDR-1:0] o_write_addr,
    output logic               o_read_enable,
    output logic [NB_ADDR-1:0] o_read_addr,
    output logic               o_rd_valid,
    output logic               o_full,
    output logic               o_busy,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        FULL    = 3'd3,
        READOUT = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(DEPTH - 1);
    localparam logic [1:0]         DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t               state;
    logic [NB_ADDR-1:0]   wr_cnt;
    logic [NB_ADDR-1:0]   rd_cnt;
    logic [1:0]           drn_cnt;
    logic                 arm_q, trig_q, req_q;
    logic                 arm_edge, trig_edge, req_edge;
    logic                 take;
    logic                 wr_en;
    logic                 rd_en;
    logic [READ_LATENCY:1] vld_pipe;

    assign arm_edge  = i_arm & ~arm_q;
    assign trig_edge = i_trigger & ~trig_q;
    assign req_edge  = i_readout_req & ~req_q;

`ifdef CAPTURE_DECIM_EN
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);
    logic [DW-1:0] dec_cnt;

    // the first valid sample after the trigger is always written
    assign take = i_decim_bypass | (dec_cnt == '0);

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            dec_cnt <= '0;
        end else if (state == ARMED && trig_edge) begin
            dec_cnt <= '0;
        end else if (state == CAPTURE && i_sample_valid) begin
            dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
        end
    end
`else
    assign take = 1'b1;
`endif

    assign wr_en = (state == CAPTURE) & i_sample_valid & take;
    assign rd_en = (state == READOUT) & i_rd_ready;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            drn_cnt <= '0;
            arm_q   <= 1'b0;
            trig_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            arm_q  <= i_arm;
            trig_q <= i_trigger;
            req_q  <= i_readout_req;
            case (state)
                IDLE: begin
                    if (arm_edge) state <= ARMED;
                end
                ARMED: begin
                    if (trig_edge) begin
                        state  <= CAPTURE;
                        wr_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        if (wr_cnt == LAST_ADDR) begin
                            wr_cnt <= '0;
                            state  <= FULL;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // readout takes priority over a simultaneous re-arm
                    if (req_edge) begin
                        state  <= READOUT;
                        rd_cnt <= '0;
                    end else if (arm_edge) begin
                        state <= ARMED;
                    end
                end
                READOUT: begin
                    if (rd_en) begin
                        if (rd_cnt == LAST_ADDR) begin
                            rd_cnt  <= '0;
                            drn_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drn_cnt == DRAIN_LAST) state <= FULL;
                    else                       drn_cnt <= drn_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // read-data valid tracks issued reads through the BRAM latency
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign o_write_enable = wr_en;
    assign o_write_addr   = wr_cnt;
    assign o_read_enable  = rd_en;
    assign o_read_addr    = rd_cnt;
    assign o_rd_valid     = vld_pipe[READ_LATENCY];
    assign o_full         = (state == FULL) | (state == READOUT) | (state == DRAIN);
    assign o_busy         = (state == CAPTURE) | (state == READOUT) | (state == DRAIN);
    assign o_state        = state;

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized bench for capture_ctrl: transaction-level expectations for capture, readout and reset.
module tb_capture_ctrl;
    localparam int NB = 4;
    localparam int D  = 16;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_arm = 1'b0, i_trigger = 1'b0, i_sample_valid = 1'b0;
    logic          i_readout_req = 1'b0, i_rd_ready = 1'b0;
    logic          i_decim_bypass = 1'b0;
    logic          o_write_enable, o_read_enable, o_rd_valid, o_full, o_busy;
    logic [NB-1:0] o_write_addr, o_read_addr;
    logic [2:0]    o_state;

    int checks = 0;
    int failures = 0;
    int ncyc, nsmp;

    always #5 clock = ~clock;

    capture_ctrl #(.NB_ADDR(NB), .DEPTH(D), .READ_LATENCY(RL)) dut (
        .clock(clock), .i_reset(i_reset), .i_arm(i_arm), .i_trigger(i_trigger),
        .i_sample_valid(i_sample_valid), .i_readout_req(i_readout_req), .i_rd_ready(i_rd_ready),
`ifdef CAPTURE_DECIM_EN
        .i_decim_bypass(i_decim_bypass),
`endif
        .o_write_enable(o_write_enable), .o_write_addr(o_write_addr),
        .o_read_enable(o_read_enable), .o_read_addr(o_read_addr), .o_rd_valid(o_rd_valid),
        .o_full(o_full), .o_busy(o_busy), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_st"},    32'(o_state), 0);
        chk({tag, "_we"},    32'(o_write_enable), 0);
        chk({tag, "_wa"},    32'(o_write_addr), 0);
        chk({tag, "_re"},    32'(o_read_enable), 0);
        chk({tag, "_ra"},    32'(o_read_addr), 0);
        chk({tag, "_rv"},    32'(o_rd_valid), 0);
        chk({tag, "_full"},  32'(o_full), 0);
        chk({tag, "_busy"},  32'(o_busy), 0);
    endtask

    // drive levels for one cycle and check the state seen during that cycle
    task automatic step(input logic a, input logic t, input logic r, input int exp_st, input string tag);
        @(negedge clock);
        i_arm = a; i_trigger = t; i_readout_req = r;
        #1 chk(tag, 32'(o_state), exp_st);
    endtask

    // from ARMED: trigger, then feed samples until D writes are expected
    // mode 0: continuous valid, 1: toggling, 2: random valid plus ignored control noise
    task automatic cap(input int mode, input int dec, output int cyc, output int smp);
        int  nwr = 0;
        logic v, ew;
        @(negedge clock);
        i_trigger = 1'b1; i_sample_valid = 1'($urandom_range(0, 1));
        #1 chk("cap_armed", 32'(o_state), 1);
        chk("cap_we_armed", 32'(o_write_enable), 0);
        cyc = 0; smp = 0;
        while (nwr < D && cyc < 400) begin
            @(negedge clock);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_sample_valid = v;
            if (mode == 2) begin
                i_arm = 1'($urandom_range(0, 1));
                i_trigger = 1'($urandom_range(0, 1));
                i_readout_req = 1'($urandom_range(0, 1));
            end else begin
                i_trigger = 1'b0;
            end
            #1;
            ew = v && (smp % dec == 0);
            chk("cap_st", 32'(o_state), 2);
            chk("cap_busy", 32'(o_busy), 1);
            chk("cap_full", 32'(o_full), 0);
            chk("cap_we", 32'(o_write_enable), 32'(ew));
            if (ew) begin
                chk("cap_addr", 32'(o_write_addr), nwr);
                nwr++;
            end
            if (v) smp++;
            cyc++;
        end
        chk("cap_nwr", nwr, D);
        @(negedge clock);
        i_sample_valid = 1'b1; i_arm = 1'b0; i_trigger = 1'b0; i_readout_req = 1'b0;
        #1;
        chk("cap_done_st", 32'(o_state), 3);
        chk("cap_done_full", 32'(o_full), 1);
        chk("cap_done_we", 32'(o_write_enable), 0);
        chk("cap_done_busy", 32'(o_busy), 0);
        i_sample_valid = 1'b0;
    endtask

    // from FULL: readout edge, then ready pattern (0: 1,1,0 repeating, 1: random)
    task automatic rdout(input int mode, input logic with_arm);
        logic hist [0:511];
        int   nrd = 0, last = -1, beats = 0, c = 0, est;
        logic rdy, ev;
        @(negedge clock);
        i_readout_req = 1'b1; i_arm = with_arm;
        #1 chk("ro_start_st", 32'(o_state), 3);
        chk("ro_start_re", 32'(o_read_enable), 0);
        while (c < 400) begin
            @(negedge clock);
            i_readout_req = 1'b0; i_arm = 1'b0;
            rdy = (mode == 0) ? (c % 3 != 2) : 1'($urandom_range(0, 1));
            i_rd_ready = rdy;
            #1;
            if (nrd < D) begin
                est = 4;
                chk("ro_re", 32'(o_read_enable), 32'(rdy));
                if (rdy) chk("ro_addr", 32'(o_read_addr), nrd);
                hist[c] = rdy;
                if (rdy) nrd++;
                if (nrd == D) last = c;
            end else begin
                est = (c <= last + RL) ? 5 : 3;
                hist[c] = 1'b0;
                chk("ro_re_drain", 32'(o_read_enable), 0);
            end
            chk("ro_st", 32'(o_state), est);
            chk("ro_full", 32'(o_full), 1);
            chk("ro_busy", 32'(o_busy), 32'(est != 3));
            ev = (c >= RL) ? hist[c-RL] : 1'b0;
            chk("ro_rv", 32'(o_rd_valid), 32'(ev));
            if (o_rd_valid === 1'b1) beats++;
            if (last >= 0 && c == last + RL + 1) break;
            c++;
        end
        chk("ro_beats", beats, D);
        i_rd_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        #2 i_reset = 1'b1;
        #1 chk_idle("rst");
        repeat (2) @(negedge clock);
        i_reset = 1'b0;
        #1 chk_idle("post_rst");

        // IDLE ignores trigger and readout
        @(negedge clock);
        i_trigger = 1'b1; i_sample_valid = 1'b1;
        #1 chk("idle_trig_we", 32'(o_write_enable), 0);
        step(0, 1, 0, 0, "idle_trig_st");
        step(0, 0, 1, 0, "idle_req");
        step(0, 0, 0, 0, "idle_hold");
        chk("idle_full", 32'(o_full), 0);
        i_sample_valid = 1'b0;

        // arm and trigger together arm only; arm in ARMED has no effect
        step(1, 1, 0, 0, "at_idle");
        step(1, 1, 0, 1, "at_armed");
        step(0, 0, 0, 1, "at_armed2");
        step(1, 0, 0, 1, "armed_arm");
        step(0, 0, 0, 1, "armed_hold");

        cap(0, 1, ncyc, nsmp);
        chk("basic_cyc", ncyc, D);
        rdout(0, 1'b0);
        rdout(1, 1'b0);

        // re-arm from FULL clears full
        step(1, 0, 0, 3, "full_arm");
        step(0, 0, 0, 1, "full_rearmed");
        chk("rearm_full", 32'(o_full), 0);
        cap(1, 1, ncyc, nsmp);
        chk("gated_cyc", ncyc, 2 * D - 1);

        // readout and arm together: readout wins
        rdout(1, 1'b1);
        step(1, 0, 0, 3, "full_arm2");
        step(0, 0, 0, 1, "armed3");
        cap(2, 1, ncyc, nsmp);
        chk("rand_smp", nsmp, D);

        // asynchronous reset at write address 7
        step(1, 0, 0, 3, "full_arm3");
        step(0, 0, 0, 1, "armed4");
        @(negedge clock);
        i_trigger = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            i_trigger = 1'b0; i_sample_valid = 1'b1;
            #1 if (o_write_enable === 1'b1 && o_write_addr === 4'd7) seen = 1'b1;
        end
        chk("rst7_seen", 32'(seen), 1);
        #2 i_reset = 1'b1;
        #1 chk_idle("rst_cap");
        @(negedge clock);
        i_reset = 1'b0;
        step(0, 1, 0, 0, "rst_trig");
        step(0, 0, 0, 0, "rst_trig2");
        chk("rst_trig_we", 32'(o_write_enable), 0);
        step(1, 0, 0, 0, "rst_arm");
        step(0, 0, 0, 1, "rst_armed");
        cap(0, 1, ncyc, nsmp);

        // asynchronous reset with read beats in flight
        @(negedge clock);
        i_readout_req = 1'b1;
        #1 chk("rrst_st", 32'(o_state), 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            i_readout_req = 1'b0; i_rd_ready = 1'b1;
        end
        #1 chk("rrst_inflight", 32'(o_rd_valid), 1);
        @(posedge clock);
        #2 i_reset = 1'b1;
        #1 chk_idle("rst_ro");
        @(negedge clock);
        i_reset = 1'b0; i_rd_ready = 1'b0;

`ifdef CAPTURE_DECIM_EN
        i_decim_bypass = 1'b0;
        step(1, 0, 0, 0, "dec_arm");
        step(0, 0, 0, 1, "dec_armed");
        cap(0, 4, ncyc, nsmp);
        chk("dec_smp", nsmp, 4 * D - 3);
        i_decim_bypass = 1'b1;
        step(1, 0, 0, 3, "byp_arm");
        step(0, 0, 0, 1, "byp_armed");
        cap(0, 1, ncyc, nsmp);
        chk("byp_smp", nsmp, D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
